// File: rtl/seg7_word_decoder.sv
// Display-side monitor: debounces the five 7-segment buses as one 35-bit word, decodes hex glyphs and flags "Error".
// Define SEG7_ACTIVE_LOW_EN to invert the segment inputs, for active-low display pins.
module seg7_word_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] seg4,
    input  logic [6:0] seg3,
    input  logic [6:0] seg2,
    input  logic [6:0] seg1,
    input  logic [6:0] seg0,
    output logic [3:0] digit4,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [4:0] digit_valid,
    output logic       word_valid,
    output logic       update,
    output logic       error_word,
    output logic       error_pulse
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);
    localparam logic [34:0] ERROR_WORD =
        {7'b1111001, 7'b1010000, 7'b1010000, 7'b1011100, 7'b1010000};

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [34:0]   word_in;
    logic [34:0]   sample;
    logic [4:0]    dec [5];
    logic          is_error;

`ifdef SEG7_ACTIVE_LOW_EN
    assign word_in = ~{seg4, seg3, seg2, seg1, seg0};
`else
    assign word_in = {seg4, seg3, seg2, seg1, seg0};
`endif

    // Returns {valid, hex}; only the canonical glyph forms count as valid.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        case (pat)
            7'b0111111: return {1'b1, 4'h0};
            7'b0000110: return {1'b1, 4'h1};
            7'b1011011: return {1'b1, 4'h2};
            7'b1001111: return {1'b1, 4'h3};
            7'b1100110: return {1'b1, 4'h4};
            7'b1101101: return {1'b1, 4'h5};
            7'b1111101: return {1'b1, 4'h6};
            7'b0000111: return {1'b1, 4'h7};
            7'b1111111: return {1'b1, 4'h8};
            7'b1101111: return {1'b1, 4'h9};
            7'b1110111: return {1'b1, 4'hA};
            7'b1111100: return {1'b1, 4'hB};
            7'b0111001: return {1'b1, 4'hC};
            7'b1011110: return {1'b1, 4'hD};
            7'b1111001: return {1'b1, 4'hE};
            7'b1110001: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    // Decoding works on the sample register, which equals the input whenever a word is accepted.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            dec[i] = decode_glyph(sample[7*i +: 7]);
        end
    end

    assign is_error = (sample == ERROR_WORD);

    // NOTE: all state here is updated with <= so every branch sees the pre-edge values of sample and error_word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sample      <= '0;
            digit4      <= '0;
            digit3      <= '0;
            digit2      <= '0;
            digit1      <= '0;
            digit0      <= '0;
            digit_valid <= '0;
            word_valid  <= 1'b0;
            update      <= 1'b0;
            error_word  <= 1'b0;
            error_pulse <= 1'b0;
        end else begin
            update      <= 1'b0;
            error_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    sample <= word_in;
                    cnt    <= '0;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    if (word_in != sample) begin
                        sample <= word_in;
                        cnt    <= '0;
                    end else if (cnt < CNT_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        state       <= LOCKED;
                        word_valid  <= 1'b1;
                        update      <= 1'b1;
                        digit4      <= dec[4][3:0];
                        digit3      <= dec[3][3:0];
                        digit2      <= dec[2][3:0];
                        digit1      <= dec[1][3:0];
                        digit0      <= dec[0][3:0];
                        digit_valid <= {dec[4][4], dec[3][4], dec[2][4], dec[1][4], dec[0][4]};
                        error_word  <= is_error;
                        error_pulse <= is_error & ~error_word;
                    end
                end
                LOCKED: begin
                    if (word_in != sample) begin
                        sample     <= word_in;
                        cnt        <= '0;
                        state      <= SETTLE;
                        word_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Directed bench for seg7_word_decoder (STABLE_CYCLES=4): vector table plus glitch and mid-settle reset sequences.
module tb_seg7_word_decoder;

    localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011, G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110, G5 = 7'b1101101, G6 = 7'b1111101, G7 = 7'b0000111;
    localparam logic [6:0] G8 = 7'b1111111, G9 = 7'b1101111, GA = 7'b1110111, GB = 7'b1111100;
    localparam logic [6:0] GC = 7'b0111001, GD = 7'b1011110, GE = 7'b1111001, GF = 7'b1110001;
    localparam logic [6:0] GR = 7'b1010000, GO = 7'b1011100, GDASH = 7'b1000000, GBLANK = 7'b0000000;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg4, seg3, seg2, seg1, seg0;
    logic [3:0] digit4, digit3, digit2, digit1, digit0;
    logic [4:0] digit_valid;
    logic       word_valid, update, error_word, error_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [34:0] segs;
        logic [19:0] digits;
        logic [4:0]  dv;
        logic        err;
        logic        pulse;
    } vec_t;

    vec_t vecs[10];

    seg7_word_decoder #(.STABLE_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .seg4(seg4), .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
        .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .digit_valid(digit_valid), .word_valid(word_valid), .update(update),
        .error_word(error_word), .error_pulse(error_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Table words are written active-high; the active-low build sees them inverted on the pins.
    task automatic drive(input logic [34:0] w);
        logic [34:0] p;
        p = w;
`ifdef SEG7_ACTIVE_LOW_EN
        p = ~w;
`endif
        {seg4, seg3, seg2, seg1, seg0} = p;
    endtask

    function automatic logic [19:0] digits_now();
        return {digit4, digit3, digit2, digit1, digit0};
    endfunction

    // Word applied before edge 1 must be accepted exactly on edge 4.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v.segs);
        for (int t = 1; t <= 3; t++) begin
            tick();
            check({tag, " update_early"}, 32'(update), 32'd0);
            if (t == 1) check({tag, " word_valid_settle"}, 32'(word_valid), 32'd0);
        end
        tick();
        check({tag, " update"},      32'(update),      32'd1);
        check({tag, " word_valid"},  32'(word_valid),  32'd1);
        check({tag, " digits"},      32'(digits_now()), 32'(v.digits));
        check({tag, " digit_valid"}, 32'(digit_valid), 32'(v.dv));
        check({tag, " error_word"},  32'(error_word),  32'(v.err));
        check({tag, " error_pulse"}, 32'(error_pulse), 32'(v.pulse));
        tick();
        check({tag, " update_off"},  32'(update),      32'd0);
        check({tag, " pulse_off"},   32'(error_pulse), 32'd0);
        check({tag, " held_valid"},  32'(word_valid),  32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " digits"},      32'(digits_now()), 32'd0);
        check({tag, " digit_valid"}, 32'(digit_valid), 32'd0);
        check({tag, " flags"},
              32'({word_valid, update, error_word, error_pulse}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{{G0, G0, G0, G0, G0},           20'h00000, 5'b11111, 1'b0, 1'b0};
        vecs[1] = '{{G1, G2, G3, G4, G5},           20'h12345, 5'b11111, 1'b0, 1'b0};
        vecs[2] = '{{G6, G7, G8, G9, GA},           20'h6789A, 5'b11111, 1'b0, 1'b0};
        vecs[3] = '{{GB, GC, GD, GE, GF},           20'hBCDEF, 5'b11111, 1'b0, 1'b0};
        vecs[4] = '{{GE, GR, GR, GO, GR},           20'hE0000, 5'b10000, 1'b1, 1'b1};
        vecs[5] = '{{GDASH, GDASH, GDASH, GDASH, GDASH}, 20'h00000, 5'b00000, 1'b0, 1'b0};
        vecs[6] = '{{GE, GR, GR, GO, 7'b1010001},   20'hE0000, 5'b10000, 1'b0, 1'b0};
        vecs[7] = '{{GE, GR, GR, GO, GR},           20'hE0000, 5'b10000, 1'b1, 1'b1};
        vecs[8] = '{{GBLANK, GBLANK, GBLANK, GBLANK, GBLANK}, 20'h00000, 5'b00000, 1'b0, 1'b0};
        vecs[9] = '{{G0, 7'b1111110, GBLANK, G8, GF}, 20'h0008F, 5'b10011, 1'b0, 1'b0};

        reset = 1'b1;
        drive('0);
        tick();
        tick();
        check_all_zero("reset");

        reset = 1'b0;
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Lock on Error, glitch seg2 for two cycles, then restore: re-accept without a second error_pulse.
        run_vec(vecs[4], "err_relock");
        drive({GE, GR, G1, GO, GR});
        for (int t = 0; t < 2; t++) begin
            tick();
            check("glitch word_valid",  32'(word_valid),   32'd0);
            check("glitch digits_held", 32'(digits_now()), 32'h000E0000);
            check("glitch dv_held",     32'(digit_valid),  32'b10000);
            check("glitch err_held",    32'(error_word),   32'd1);
        end
        drive(vecs[4].segs);
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("restore update_early", 32'(update), 32'd0);
        end
        tick();
        check("restore update",      32'(update),      32'd1);
        check("restore word_valid",  32'(word_valid),  32'd1);
        check("restore error_word",  32'(error_word),  32'd1);
        check("restore error_pulse", 32'(error_pulse), 32'd0);

        // Reset while settling (cnt=1): outputs clear on that edge, then a clean accept follows.
        drive({G1, G1, G1, G1, G1});
        tick();
        tick();
        check("midreset settling", 32'(word_valid), 32'd0);
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            check("postreset update_early", 32'(update), 32'd0);
        end
        tick();
        check("postreset update",      32'(update),       32'd1);
        check("postreset digits",      32'(digits_now()), 32'h00011111);
        check("postreset digit_valid", 32'(digit_valid),  32'b11111);
        check("postreset error_word",  32'(error_word),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
